// File: rtl/nios_system_pio_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios_system_pio_ext                                                      |
// | Avalon-MM GPIO: per-bit direction, set/clear, synchronised edge capture. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nios_system_pio_ext #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    EDGE_TYPE   = 0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  localparam logic [2:0] c_ADDR_DATA = 3'd0;
  localparam logic [2:0] c_ADDR_DIR  = 3'd1;
  localparam logic [2:0] c_ADDR_MASK = 3'd2;
  localparam logic [2:0] c_ADDR_EDGE = 3'd3;
  localparam logic [2:0] c_ADDR_SET  = 3'd4;
  localparam logic [2:0] c_ADDR_CLR  = 3'd5;
  localparam logic [2:0] c_WARM_MAX  = 3'(SYNC_STAGES + 1);

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_in_sync;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] w_detect;
  logic [DATA_WIDTH-1:0] w_clr;
  logic                  w_unused;

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [2:0]            r_warm;

  assign w_wr      = chipselect & ~write_n;
  assign w_wd      = writedata[DATA_WIDTH-1:0];
  assign w_unused  = ^writedata;
  assign w_in_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_mask     <= '0;
    end else if (w_wr) begin
      case (address)
        c_ADDR_DATA: r_data_out <= w_wd;
        c_ADDR_DIR:  r_dir      <= w_wd;
        c_ADDR_MASK: r_mask     <= w_wd;
        c_ADDR_SET:  r_data_out <= r_data_out | w_wd;
        c_ADDR_CLR:  r_data_out <= r_data_out & ~w_wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_in_sync;
      if (r_warm != c_WARM_MAX) r_warm <= r_warm + 3'd1;
    end
  end

  assign w_rise = w_in_sync & ~r_prev;
  assign w_fall = ~w_in_sync & r_prev;

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_sel = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_sel = w_fall;
    end else begin : g_edge_any
      assign w_sel = w_rise | w_fall;
    end
  endgenerate

  // Edges are ignored until the synchroniser has flushed its reset zeros.
  assign w_detect = (r_warm == c_WARM_MAX) ? (w_sel & ~r_dir) : '0;
  assign w_clr    = (w_wr && address == c_ADDR_EDGE) ? w_wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cap <= '0;
    else          r_cap <= (r_cap & ~w_clr) | w_detect;
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        c_ADDR_DATA: readdata[DATA_WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & w_in_sync);
        c_ADDR_DIR:  readdata[DATA_WIDTH-1:0] = r_dir;
        c_ADDR_MASK: readdata[DATA_WIDTH-1:0] = r_mask;
        c_ADDR_EDGE: readdata[DATA_WIDTH-1:0] = r_cap;
        default:     readdata = '0;
      endcase
    end
  end

  assign out_port = r_data_out;
  assign oe       = r_dir;
  assign irq      = |(r_cap & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios_system_pio_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nios_system_pio_ext                                                   |
// | Scoreboarded bench: rising-edge and any-edge instances on a shared bus.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nios_system_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd2;
  logic [7:0]  out0, out2, oe0, oe2;
  logic        irq0, irq2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] e0;
    logic [31:0] e2;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  always #5 clk = ~clk;

  nios_system_pio_ext #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
    .out_port(out0), .oe(oe0), .irq(irq0)
  );

  nios_system_pio_ext #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
    .out_port(out2), .oe(oe2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e2);
    rd_exp_t x;
    sb_q.push_back('{tag, e0, e2});
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    x = sb_q.pop_front();
    check({x.tag, "/rise"}, rd0, x.e0);
    check({x.tag, "/any"},  rd2, x.e2);
    chipselect = 1'b0;
  endtask

  task automatic pins(input string tag, input logic [7:0] o, input logic [7:0] e, input logic q0, input logic q2);
    check({tag, "/out_rise"}, 32'(out0), 32'(o));
    check({tag, "/out_any"},  32'(out2), 32'(o));
    check({tag, "/oe_rise"},  32'(oe0),  32'(e));
    check({tag, "/oe_any"},   32'(oe2),  32'(e));
    check({tag, "/irq_rise"}, 32'(irq0), 32'(q0));
    check({tag, "/irq_any"},  32'(irq2), 32'(q2));
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'h3C;
    tick(3);
    pins("reset", 8'hA5, 8'h00, 1'b0, 1'b0);
    check("rd_no_cs", rd0, 32'h0);
    reset_n = 1'b1;
    tick(2);
    rd("sync_data", 3'd0, 32'h3C, 32'h3C);
    tick(3);
    rd("warm_cap", 3'd3, 32'h0, 32'h0);

    // Direction, set and clear.
    wr(3'd1, 32'h0F);
    wr(3'd0, 32'hFF);
    pins("wr_data", 8'hFF, 8'h0F, 1'b0, 1'b0);
    wr(3'd5, 32'h05);
    pins("outclear", 8'hFA, 8'h0F, 1'b0, 1'b0);
    wr(3'd4, 32'h30);
    pins("outset", 8'hFA, 8'h0F, 1'b0, 1'b0);
    rd("mixed_data", 3'd0, 32'h3A, 32'h3A);
    rd("rd_set", 3'd4, 32'h0, 32'h0);
    rd("rd_clr", 3'd5, 32'h0, 32'h0);
    rd("rd_a6", 3'd6, 32'h0, 32'h0);
    wr(3'd6, 32'hFF);
    rd("dir_after_a6", 3'd1, 32'h0F, 32'h0F);
    pins("a6_ignored", 8'hFA, 8'h0F, 1'b0, 1'b0);

    // Rising edge on bit 7 with capture latency.
    wr(3'd1, 32'h00);
    pins("dir_change", 8'hFA, 8'h00, 1'b0, 1'b0);
    wr(3'd2, 32'h80);
    in_port = 8'hBC;
    tick(2);
    rd("cap_early", 3'd3, 32'h0, 32'h0);
    pins("irq_early", 8'hFA, 8'h00, 1'b0, 1'b0);
    tick(1);
    rd("cap_rise", 3'd3, 32'h80, 32'h80);
    pins("irq_rise", 8'hFA, 8'h00, 1'b1, 1'b1);
    wr(3'd3, 32'h80);
    pins("irq_cleared", 8'hFA, 8'h00, 1'b0, 1'b0);
    rd("cap_cleared", 3'd3, 32'h0, 32'h0);
    in_port = 8'h3C;
    tick(4);
    rd("cap_fall", 3'd3, 32'h0, 32'h80);
    pins("irq_fall", 8'hFA, 8'h00, 1'b0, 1'b1);
    wr(3'd3, 32'hFF);

    // Capture set racing a clear of the same bit.
    in_port = 8'h00;
    tick(5);
    wr(3'd3, 32'hFF);
    rd("cap_zero", 3'd3, 32'h0, 32'h0);
    in_port = 8'h02;
    tick(4);
    rd("cap_bit1", 3'd3, 32'h02, 32'h02);
    in_port = 8'h06;
    tick(2);
    wr(3'd3, 32'h06);
    rd("set_wins", 3'd3, 32'h04, 32'h04);
    pins("masked_off", 8'hFA, 8'h00, 1'b0, 1'b0);
    wr(3'd2, 32'h04);
    pins("mask_on", 8'hFA, 8'h00, 1'b1, 1'b1);
    wr(3'd2, 32'h00);
    pins("mask_off", 8'hFA, 8'h00, 1'b0, 1'b0);

    // Output bits never capture.
    wr(3'd3, 32'hFF);
    wr(3'd1, 32'h01);
    in_port = 8'h07;
    tick(4);
    in_port = 8'h06;
    tick(4);
    rd("out_no_cap", 3'd3, 32'h0, 32'h0);
    rd("out_data", 3'd0, 32'h06, 32'h06);

    // Asynchronous reset while a capture is pending.
    wr(3'd1, 32'h00);
    wr(3'd2, 32'hFF);
    in_port = 8'h07;
    tick(4);
    rd("cap_pre_rst", 3'd3, 32'h01, 32'h01);
    pins("irq_pre_rst", 8'hFA, 8'h00, 1'b1, 1'b1);
    in_port = 8'hFF;
    reset_n = 1'b0;
    #1;
    pins("async_rst", 8'hA5, 8'h00, 1'b0, 1'b0);
    rd("cap_in_rst", 3'd3, 32'h0, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(8);
    rd("held_high", 3'd3, 32'h0, 32'h0);
    rd("held_data", 3'd0, 32'hFF, 32'hFF);
    in_port = 8'hFE;
    tick(4);
    rd("fall_after_rst", 3'd3, 32'h0, 32'h01);
    pins("mask_rst", 8'hA5, 8'h00, 1'b0, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
